// File: rtl/mem_writeback_stage.sv
// MEM/WB pipeline stage: performs lw/sw against a private word-addressed data
// memory with a fixed access latency, and registers the write-back pair that
// the register file consumes. Upstream is frozen through `stall` while an
// access is in flight.
module mem_writeback_stage #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned MEM_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        XM_valid,
    input  logic [31:0] XM_ALUout,
    input  logic [4:0]  XM_RD,
    input  logic        XM_MemToReg,
    input  logic        XM_MemWrite,
    input  logic [31:0] XM_RT,
    output logic [4:0]  MW_RD,
    output logic [31:0] MW_ALUout,
    output logic        stall,
    output logic        addr_err
);

    localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CntInit = 4'(MEM_LAT - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  mw_rd_q, mw_rd_d;
    logic [31:0] mw_alu_q, mw_alu_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0]           mem_q [0:Depth-1];
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  mem_we;
    logic                  mem_op;
    logic                  misaligned;

    // Upper address bits are ignored so accesses wrap modulo the memory size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^XM_ALUout[31:DEPTH_LOG2+2];

    assign mem_idx    = XM_ALUout[DEPTH_LOG2+1:2];
    assign mem_op     = XM_valid & (XM_MemToReg | XM_MemWrite);
    assign misaligned = (XM_ALUout[1:0] != 2'b00);

    // Next-state, write-back and stall decode; MemWrite wins when both flags set.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mw_rd_d    = mw_rd_q;
        mw_alu_d   = mw_alu_q;
        addr_err_d = 1'b0;
        stall      = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            StIdle: begin
                if (!XM_valid) begin
                    mw_rd_d = 5'd0;
                end else if (!mem_op) begin
                    mw_rd_d  = XM_RD;
                    mw_alu_d = XM_ALUout;
                end else if (misaligned) begin
                    mw_rd_d    = 5'd0;
                    addr_err_d = 1'b1;
                end else begin
                    stall   = 1'b1;
                    state_d = StAccess;
                    cnt_d   = CntInit;
                    mw_rd_d = 5'd0;
                end
            end
            StAccess: begin
                if (cnt_q != 4'd0) begin
                    stall   = 1'b1;
                    cnt_d   = cnt_q - 4'd1;
                    mw_rd_d = 5'd0;
                end else begin
                    state_d = StIdle;
                    if (XM_MemWrite) begin
                        mem_we  = 1'b1;
                        mw_rd_d = 5'd0;
                    end else begin
                        mw_alu_d = mem_q[mem_idx];
                        mw_rd_d  = XM_RD;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Pipeline state; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            mw_rd_q    <= 5'd0;
            mw_alu_q   <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mw_rd_q    <= mw_rd_d;
            mw_alu_q   <= mw_alu_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Data memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= XM_RT;
        end
    end

    assign MW_RD     = mw_rd_q;
    assign MW_ALUout = mw_alu_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Randomized bench for mem_writeback_stage with a transaction-level model.
module tb_mem_writeback_stage;

    localparam int unsigned DL    = 10;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        XM_valid = 1'b0;
    logic [31:0] XM_ALUout = 32'd0;
    logic [4:0]  XM_RD = 5'd0;
    logic        XM_MemToReg = 1'b0;
    logic        XM_MemWrite = 1'b0;
    logic [31:0] XM_RT = 32'd0;
    logic [4:0]  MW_RD;
    logic [31:0] MW_ALUout;
    logic        stall;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mm [DEPTH];
    logic [4:0]  exp_rd;
    logic [31:0] exp_alu;
    logic        exp_err;

    mem_writeback_stage #(.DEPTH_LOG2(DL), .MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .XM_valid   (XM_valid),
        .XM_ALUout  (XM_ALUout),
        .XM_RD      (XM_RD),
        .XM_MemToReg(XM_MemToReg),
        .XM_MemWrite(XM_MemWrite),
        .XM_RT      (XM_RT),
        .MW_RD      (MW_RD),
        .MW_ALUout  (MW_ALUout),
        .stall      (stall),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction and follow it until it has been consumed.
    task automatic issue(input bit v, input bit ld, input bit st, input logic [31:0] a,
                         input logic [4:0] rd, input logic [31:0] rt);
        bit mop;
        int idx;
        mop = v && (ld || st);
        idx = int'((a / 4) % DEPTH);
        XM_valid = v; XM_MemToReg = ld; XM_MemWrite = st;
        XM_ALUout = a; XM_RD = rd; XM_RT = rt;
        #1;
        if (mop && (a % 4 == 0)) begin
            for (int k = 0; k < LAT; k++) begin
                check_eq("stall_busy", 32'(stall), 32'd1);
                @(posedge clk); #1;
                check_eq("bubble_rd", 32'(MW_RD), 32'd0);
                check_eq("bubble_err", 32'(addr_err), 32'd0);
                check_eq("bubble_alu", MW_ALUout, exp_alu);
            end
            check_eq("stall_done", 32'(stall), 32'd0);
            @(posedge clk); #1;
            if (st) begin
                mm[idx] = rt;
                exp_rd  = 5'd0;
            end else begin
                exp_alu = mm[idx];
                exp_rd  = rd;
            end
            exp_err = 1'b0;
        end else begin
            check_eq("stall_idle", 32'(stall), 32'd0);
            @(posedge clk); #1;
            exp_err = 1'b0;
            if (!v) begin
                exp_rd = 5'd0;
            end else if (!mop) begin
                exp_rd  = rd;
                exp_alu = a;
            end else begin
                exp_rd  = 5'd0;
                exp_err = 1'b1;
            end
        end
        check_eq("wb_rd", 32'(MW_RD), 32'(exp_rd));
        check_eq("wb_alu", MW_ALUout, exp_alu);
        check_eq("addr_err", 32'(addr_err), 32'(exp_err));
    endtask

    initial begin
        logic [31:0] prior;
        exp_rd = 5'd0; exp_alu = 32'd0; exp_err = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_eq("rst_rd", 32'(MW_RD), 32'd0);
        check_eq("rst_alu", MW_ALUout, 32'd0);
        check_eq("rst_err", 32'(addr_err), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Plain ALU op.
        issue(1, 0, 0, 32'h1234, 5'd5, 32'd0);
        check_eq("t1_alu", MW_ALUout, 32'h1234);

        // Preload the word window used by the random phase.
        for (int w = 0; w < 16; w++) issue(1, 0, 1, 32'(w * 4), 5'd0, $urandom);

        // Store then load.
        issue(1, 0, 1, 32'h10, 5'd0, 32'hDEADBEEF);
        issue(1, 1, 0, 32'h10, 5'd8, 32'd0);
        check_eq("t2_lw", MW_ALUout, 32'hDEADBEEF);

        // Misaligned load and store leave memory untouched.
        issue(1, 1, 0, 32'h6, 5'd3, 32'd0);
        issue(1, 0, 1, 32'h6, 5'd0, 32'hBAD0BAD0);
        issue(0, 0, 0, 32'h0, 5'd0, 32'd0);
        issue(1, 1, 0, 32'h4, 5'd2, 32'd0);

        // Address wrap.
        issue(1, 0, 1, 32'h1000, 5'd0, 32'hCAFEF00D);
        issue(1, 1, 0, 32'h0, 5'd7, 32'd0);
        check_eq("t4_wrap", MW_ALUout, 32'hCAFEF00D);

        // Reset in the middle of a store aborts the write.
        prior = mm[8];
        XM_valid = 1; XM_MemToReg = 0; XM_MemWrite = 1;
        XM_ALUout = 32'h20; XM_RD = 0; XM_RT = 32'h55;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("t5_rd", 32'(MW_RD), 32'd0);
        check_eq("t5_alu", MW_ALUout, 32'd0);
        check_eq("t5_err", 32'(addr_err), 32'd0);
        XM_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_rd = 5'd0; exp_alu = 32'd0; exp_err = 1'b0;
        issue(1, 1, 0, 32'h20, 5'd4, 32'd0);
        check_eq("t5_prior", MW_ALUout, prior);

        // Back-to-back lw, sw, lw, add; lw with rd 0 yields no write-back.
        issue(1, 1, 0, 32'h8, 5'd8, 32'd0);
        issue(1, 0, 1, 32'hC, 5'd0, 32'h01020304);
        issue(1, 1, 0, 32'hC, 5'd9, 32'd0);
        issue(1, 0, 0, 32'h777, 5'd3, 32'd0);
        issue(1, 1, 0, 32'h8, 5'd0, 32'd0);

        // Randomized mix.
        for (int i = 0; i < 300; i++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            a = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            case (kind)
                0:       issue(0, $urandom_range(0, 1), $urandom_range(0, 1), a, 5'($urandom), $urandom);
                1, 2, 3: issue(1, 0, 0, $urandom, 5'($urandom), $urandom);
                4, 5, 6: issue(1, 1, 0, a, 5'($urandom), $urandom);
                7, 8:    issue(1, 0, 1, a, 5'($urandom), $urandom);
                default: issue(1, 1, 1, a, 5'($urandom), $urandom);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
